core_bench_cpu: RTL and testbench
=================================

// Module: core_bench_cpu
// PURPOSE
//  Minimal 4-bit E0C6S46-style CPU core used as the unit-level instruction bench target. It covers page-select
//  (PSET), jump (JP), NOP5/NOP7, EI/DI and the 12-cycle interrupt entry.
//  The core fetches 12-bit ROM words and pushes PC nibbles to 4-bit RAM on interrupt.
// PARAMETERS
//  RESET_PC    13'h0100  PC after reset: bank 0, page 1, step 00.
//  RESET_SP    8'h00     stack pointer after reset.
// PORTS
//  clk            in   1   system clock; every internal register updates on posedge.
//  reset_n        in   1   asynchronous, active-low reset.
//  rom_addr       out  13  fetch address (= pc).
//  rom_data       in   12  instruction word; sampled in cycle 0 of each instruction.
//  ram_addr       out  8   RAM address for stack pushes.
//  ram_wdata      out  4   RAM write nibble.
//  ram_we         out  1   RAM write strobe; ram_addr/ram_wdata are valid while it is high.
//  interrupt_req  in   15  interrupt request lines; bit 0 has the highest priority.
//  instr_done     out  1   one-clock pulse in the last cycle of each instruction or interrupt entry.
//  pc             out  13  {bank[12], page[11:8], step[7:0]}.
//  np             out  5   new-page register {bank, page}.
//  sp             out  8   stack pointer.
//  i_flag         out  1   interrupt enable flag.
// BEHAVIOUR
//  - Reset values: pc = RESET_PC, np = 5'h01 (= RESET_PC[12:8]), sp = RESET_SP, i_flag = 0.
//    Also: ram_we = 0, instr_done = 0, and the internal pset_last flag = 0.
//  - Reset asserted mid-instruction aborts the instruction immediately. No RAM write completes after that.
//  - Instruction length is 5 clocks (stages 0..4), except NOP7, which takes 7 clocks.
//    pc and np commit in the last stage, together with instr_done.
//  - Decode:
//    - 0x0ss JP s: pc <= {np, s}.
//    - 0xE4p / 0xE5p PSET: np <= word[4:0]; pc + 1; sets pset_last.
//    - 0xFFB NOP5: pc + 1.
//    - 0xFFF NOP7: pc + 1.
//    - 0xF48 EI: i_flag <= 1.
//    - 0xF57 DI: i_flag <= 0.
//    - Any other word executes as NOP5.
//  - Every non-PSET instruction reloads np <= next_pc[12:8] at completion.
//    Example: np = 0x1A, NOP5 at 0x0100 -> np = 0x01.
//    A following JP uses the PSET value only when the PSET immediately precedes it.
//  - PC increment is 13-bit and wraps at 0x1FFF -> 0x0000.
//  - Interrupt check happens at each instruction boundary. Entry requires all of:
//    i_flag = 1, |interrupt_req != 0, and pset_last == 0.
//    Otherwise the next instruction is fetched.
//    - A request arriving during PSET or during the instruction after PSET is deferred until that instruction ends.
//    - pset_last clears when any non-PSET instruction completes.
//  - Interrupt entry takes 12 clocks (stages 0..11). It is latched at entry, so deasserting the request later
//    does not cancel it.
//    - Stage 2 (STEP2): i_flag <= 0.
//    - Stages 3/5/7 write, in order:
//      - RAM[sp-1] = pc[11:8] (page)
//      - RAM[sp-2] = pc[7:4]
//      - RAM[sp-3] = pc[3:0]
//    - Stage 11: sp <= sp - 3 (8-bit wrap).
//      pc <= {pc[12], 4'h1, 2*k+1}, where k is the lowest set request bit. np <= pc[12:8] new value.
//      instr_done pulses.
//  - Simultaneous EI and pending request: i_flag is read after the EI commit, so entry follows EI immediately.
// CONFIGURATION
//  - CORE_INTERRUPT_EN defined: the interrupt sequencer, RAM push and STEP2 flag clear are present.
//  - CORE_INTERRUPT_EN undefined: interrupt_req is ignored, ram_we is tied 0, and i_flag is still
//    set/cleared by EI/DI.
// TESTING
//  - PSET 0xE4F from reset -> np = 0x0F, pc = 0x0101, 5 clocks, all other registers unchanged.
//  - PSET 0xE54 -> np = 0x14, pc + 1, 5 clocks.
//  - np forced to 0x1A, then NOP5 -> np = 0x01.
//    Then JP 0xA5 -> pc = 0x01A5, np = 0x01.
//  - Interrupt deferral (i_flag = 1, sp = S):
//    - Run PSET 0xE59 and raise interrupt_req = 0x0001 at 2 ns.
//    - The following JP 0xE1 executes with no interrupt entry -> pc = 0x19E1.
//    - The request is dropped after the JP; the interrupt entry then runs anyway.
//    - Expected: i_flag = 0 by STEP2; total 22 clocks (5 + 5 + 12).
//    - Expected: pc = 0x1101; RAM[S-1] = 9, RAM[S-2] = E, RAM[S-3] = 1; sp = S - 3.
//  - i_flag = 0 with interrupt_req = 0x7FFF -> no entry; NOP5 sequence continues.
//  - interrupt_req = 0x0004 at a boundary -> pc step = 0x05.
//    reset_n pulsed low at interrupt stage 4 -> registers return to reset values.

Source files
------------

// File: rtl/core_bench_cpu.sv
// core_bench_cpu -- minimal 4-bit E0C6S46-style core used as an instruction bench target.
// Executes PSET, JP, NOP5, NOP7, EI and DI. Every other word executes as NOP5.
// Optionally runs the 12-clock interrupt entry, which pushes the PC nibbles to RAM.
//
// Optional feature: define CORE_INTERRUPT_EN to build the interrupt sequencer,
// the RAM stack push and the STEP2 flag clear. Without it, interrupt_req is
// ignored, ram_we is tied low, and EI/DI still set and clear i_flag.
//
// Ports:
//   clk, reset_n   clock; asynchronous active-low reset
//   rom_addr       fetch address (= pc)
//   rom_data       instruction word, sampled in stage 0
//   ram_addr/ram_wdata/ram_we   stack push port (valid while ram_we is high)
//   interrupt_req  15 request lines, bit 0 has the highest priority
//   instr_done     high in the last clock of an instruction or interrupt entry
//   pc, np, sp, i_flag   architectural state
`timescale 1ns/1ps
module core_bench_cpu #(
  parameter logic [12:0] RESET_PC = 13'h0100,
  parameter logic [7:0]  RESET_SP = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [12:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [7:0]  ram_addr,
  output logic [3:0]  ram_wdata,
  output logic        ram_we,
  input  logic [14:0] interrupt_req,
  output logic        instr_done,
  output logic [12:0] pc,
  output logic [4:0]  np,
  output logic [7:0]  sp,
  output logic        i_flag
);

  localparam logic [11:0] OP_NOP7 = 12'hFFF;
  localparam logic [11:0] OP_EI   = 12'hF48;
  localparam logic [11:0] OP_DI   = 12'hF57;

  typedef enum logic {ST_EXEC, ST_INT} state_t;

  state_t      state, state_n;
  logic [3:0]  stage, stage_n;
  logic [11:0] ir, ir_n;
  logic [12:0] pc_n, pc_inc;
  logic [4:0]  np_n;
  logic [7:0]  sp_n;
  logic        if_n;
  logic        pset_last, pl_n;
  logic [11:0] word;
  logic        last;

`ifdef CORE_INTERRUPT_EN
  logic [3:0] vec_k, k_n;

  // Index of the lowest set request bit (bit 0 wins).
  function automatic logic [3:0] lowest_req(input logic [14:0] r);
    lowest_req = '0;
    for (int i = 14; i >= 0; i--)
      if (r[i]) lowest_req = 4'(i);
  endfunction
`else
  logic unused_int;
  assign unused_int = ^interrupt_req;
`endif

  assign rom_addr = pc;
  assign pc_inc   = pc + 13'd1;
  // rom_data is only meaningful in stage 0; later stages decode the latched word.
  assign word     = (stage == 4'd0) ? rom_data : ir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_EXEC;
      stage     <= '0;
      ir        <= '0;
      pc        <= RESET_PC;
      np        <= RESET_PC[12:8];
      sp        <= RESET_SP;
      i_flag    <= 1'b0;
      pset_last <= 1'b0;
`ifdef CORE_INTERRUPT_EN
      vec_k     <= '0;
`endif
    end else begin
      state     <= state_n;
      stage     <= stage_n;
      ir        <= ir_n;
      pc        <= pc_n;
      np        <= np_n;
      sp        <= sp_n;
      i_flag    <= if_n;
      pset_last <= pl_n;
`ifdef CORE_INTERRUPT_EN
      vec_k     <= k_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    stage_n    = stage + 4'd1;
    ir_n       = ir;
    pc_n       = pc;
    np_n       = np;
    sp_n       = sp;
    if_n       = i_flag;
    pl_n       = pset_last;
    last       = 1'b0;
    instr_done = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = sp;
    ram_wdata  = '0;
`ifdef CORE_INTERRUPT_EN
    k_n        = vec_k;
`endif

    if (state == ST_EXEC) begin
      if (stage == 4'd0) ir_n = rom_data;
      last = (stage == ((word == OP_NOP7) ? 4'd6 : 4'd4));
      if (last) begin
        instr_done = 1'b1;
        if (word[11:8] == 4'h0) begin
          // JP: np already holds the target page, so the reload leaves it unchanged.
          pc_n = {np, word[7:0]};
          pl_n = 1'b0;
        end else if (word[11:5] == 7'b1110010) begin
          np_n = word[4:0];
          pc_n = pc_inc;
          pl_n = 1'b1;
        end else begin
          pc_n = pc_inc;
          np_n = pc_inc[12:8];
          pl_n = 1'b0;
          if (word == OP_EI)      if_n = 1'b1;
          else if (word == OP_DI) if_n = 1'b0;
        end
      end
    end
`ifdef CORE_INTERRUPT_EN
    else begin
      if (stage == 4'd2) if_n = 1'b0;
      // Push page, then high step nibble, then low step nibble, going down from sp.
      case (stage)
        4'd3: begin ram_we = 1'b1; ram_addr = sp - 8'd1; ram_wdata = pc[11:8]; end
        4'd5: begin ram_we = 1'b1; ram_addr = sp - 8'd2; ram_wdata = pc[7:4];  end
        4'd7: begin ram_we = 1'b1; ram_addr = sp - 8'd3; ram_wdata = pc[3:0];  end
        default: ;
      endcase
      if (stage == 4'd11) begin
        last       = 1'b1;
        instr_done = 1'b1;
        sp_n       = sp - 8'd3;
        pc_n       = {pc[12], 4'h1, 3'b000, vec_k, 1'b1};
        np_n       = {pc[12], 4'h1};
      end
    end
`endif

    // Boundary: the entry decision sees the flags as they are after this commit,
    // so an EI enters at once and a PSET defers the next instruction.
    if (last) begin
      stage_n = '0;
      state_n = ST_EXEC;
`ifdef CORE_INTERRUPT_EN
      if (if_n && (|interrupt_req) && !pl_n) begin
        state_n = ST_INT;
        k_n     = lowest_req(interrupt_req);
      end
`endif
    end
  end

endmodule

// File: tb/tb_core_bench_cpu.sv
`timescale 1ns/1ps
module tb_core_bench_cpu;

`ifdef CORE_INTERRUPT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] rom_addr;
  logic [11:0] rom_data;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_wdata;
  logic        ram_we;
  logic [14:0] interrupt_req = '0;
  logic        instr_done;
  logic [12:0] pc;
  logic [4:0]  np;
  logic [7:0]  sp;
  logic        i_flag;

  core_bench_cpu dut (
    .clk(clk), .reset_n(reset_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .interrupt_req(interrupt_req), .instr_done(instr_done),
    .pc(pc), .np(np), .sp(sp), .i_flag(i_flag)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [0:8191];
  logic [3:0]  ram [0:255];
  assign rom_data = rom[rom_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  logic [12:0] m_pc;
  logic [4:0]  m_np;
  logic [7:0]  m_sp;
  bit          m_if, m_pl, m_int;
  int          m_cyc, m_len, m_k;
  logic [11:0] m_word;

  function automatic int low_bit(input logic [14:0] r);
    for (int i = 0; i < 15; i++) if (r[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = 13'h0100; m_np = 5'h01; m_sp = 8'h00;
      m_if = 0; m_pl = 0; m_int = 0; m_cyc = 0; m_len = 5; m_k = 0; m_word = '0;
    end else begin
      if (!m_int && m_cyc == 0) begin
        m_word = rom_data;
        m_len  = (rom_data == 12'hFFF) ? 7 : 5;
      end
      if (m_int && m_cyc == 2) m_if = 0;
      if (m_cyc == m_len - 1) begin
        if (m_int) begin
          m_sp = m_sp - 8'd3;
          m_pc = {m_pc[12], 4'h1, 8'(2 * m_k + 1)};
          m_np = m_pc[12:8];
        end else if (m_word[11:8] == 4'h0) begin
          m_pc = {m_np, m_word[7:0]};
          m_pl = 0;
        end else if (m_word[11:8] == 4'hE && (m_word[7:4] == 4'h4 || m_word[7:4] == 4'h5)) begin
          m_np = m_word[4:0];
          m_pc = m_pc + 13'd1;
          m_pl = 1;
        end else begin
          m_pc = m_pc + 13'd1;
          m_np = m_pc[12:8];
          m_pl = 0;
          if (m_word == 12'hF48) m_if = 1;
          if (m_word == 12'hF57) m_if = 0;
        end
        m_cyc = 0;
        if (INT_EN && m_if && interrupt_req != 0 && !m_pl) begin
          m_int = 1; m_len = 12; m_k = low_bit(interrupt_req);
        end else m_int = 0;
      end else m_cyc++;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      automatic bit exp_we = m_int && (m_cyc == 3 || m_cyc == 5 || m_cyc == 7);
      chk("pc", pc, m_pc);
      chk("rom_addr", rom_addr, m_pc);
      chk("np", np, m_np);
      chk("sp", sp, m_sp);
      chk("i_flag", i_flag, m_if);
      chk("instr_done", instr_done, (m_cyc == m_len - 1));
      chk("ram_we", ram_we, exp_we);
      if (exp_we) begin
        automatic int idx = (m_cyc - 3) / 2;
        chk("ram_addr", ram_addr, m_sp - 8'(idx + 1));
        chk("ram_wdata", ram_wdata, (idx == 0) ? m_pc[11:8] : (idx == 1) ? m_pc[7:4] : m_pc[3:0]);
      end
    end
  end

  // Waits for the end of the current instruction, returns its clock count and
  // leaves time just after the committing edge.
  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (instr_done) break;
      if (n >= 40) begin
        total++; bad++;
        $display("FAIL done_timeout: got no instr_done after %0d clocks want done", n);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_pc", pc, 13'h0100);
    chk("rst_np", np, 5'h01);
    chk("rst_sp", sp, 8'h00);
    chk("rst_if", i_flag, 1'b0);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_done", instr_done, 1'b0);
  endtask

  function automatic logic [11:0] rand_word();
    case ($urandom_range(0, 9))
      0, 1:    return {4'h0, 8'($urandom)};
      2, 3:    return {7'b1110010, 5'($urandom)};
      4:       return 12'hFFB;
      5:       return 12'hFFF;
      6, 8:    return 12'hF48;
      7:       return 12'hF57;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    int n, n1, n2, n3;
    for (int i = 0; i < 8192; i++) rom[i] = 12'hFFB;
    rom[13'h0100] = 12'hE4F;
    rom[13'h0101] = 12'hE54;
    rom[13'h0102] = 12'hE5A;
    rom[13'h0103] = 12'hFFB;
    rom[13'h0104] = 12'h0A5;
    rom[13'h01A5] = 12'hF48;
    rom[13'h01A6] = 12'hE59;
    rom[13'h01A7] = 12'h0E1;
    rom[13'h1103] = 12'hF48;
    rom[13'h1105] = 12'hF48;

    repeat (2) @(negedge clk);
    chk_reset_state();
    @(posedge clk); #1 reset_n = 1'b1;

    wait_done(n);
    chk("pset_len", n, 5);
    chk("pset_np", np, 5'h0F);
    chk("pset_pc", pc, 13'h0101);
    chk("pset_sp", sp, 8'h00);
    chk("pset_if", i_flag, 1'b0);
    wait_done(n);
    chk("pset2_np", np, 5'h14);
    chk("pset2_pc", pc, 13'h0102);
    wait_done(n);
    chk("pset3_np", np, 5'h1A);
    wait_done(n);
    chk("nop_np_reload", np, 5'h01);
    chk("nop_pc", pc, 13'h0104);
    wait_done(n);
    chk("jp_pc", pc, 13'h01A5);
    chk("jp_np", np, 5'h01);
    wait_done(n);
    chk("ei_flag", i_flag, 1'b1);

    interrupt_req = 15'h0001;
    wait_done(n1);
    chk("defer_pset_np", np, 5'h19);
    wait_done(n2);
    chk("defer_jp_pc", pc, 13'h19E1);
    interrupt_req = '0;
`ifdef CORE_INTERRUPT_EN
    wait_done(n3);
    chk("int_clocks", n1 + n2 + n3, 22);
    chk("int_pc", pc, 13'h1101);
    chk("int_np", np, 5'h11);
    chk("int_sp", sp, 8'hFD);
    chk("int_if", i_flag, 1'b0);
    chk("push_page", ram[8'hFF], 4'h9);
    chk("push_hi", ram[8'hFE], 4'hE);
    chk("push_lo", ram[8'hFD], 4'h1);

    interrupt_req = 15'h7FFF;
    wait_done(n);
    wait_done(n);
    chk("masked_pc", pc, 13'h1103);
    chk("masked_sp", sp, 8'hFD);

    interrupt_req = 15'h0004;
    wait_done(n);
    wait_done(n);
    chk("int2_len", n, 12);
    chk("int2_pc", pc, 13'h1105);
    chk("int2_sp", sp, 8'hFA);
    chk("int2_push_lo", ram[8'hFA], 4'h4);
    wait_done(n);
`else
    interrupt_req = 15'h7FFF;
    wait_done(n);
    chk("noint_pc", pc, 13'h19E2);
    chk("noint_sp", sp, 8'h00);
`endif
    // Abort in stage 4 of whatever is running now.
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk_reset_state();

    // Randomized program and requests against the model.
    interrupt_req = '0;
    for (int i = 0; i < 8192; i++) rom[i] = rand_word();
    @(posedge clk); #1 reset_n = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0, 3: interrupt_req = '0;
          1:    interrupt_req = 15'(1 << $urandom_range(0, 14));
          default: interrupt_req = 15'($urandom);
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
